palette_colorizer: RTL

Pipelined, parametrised successor to the display colorizer. Resolves a world-map pixel and NUM_ICONS prioritised icon layers into 12-bit RGB through run-time-writable palette registers, with per-icon blinking. Sits between the world/icon pixel generators and the VGA output pins. Outputs are registered and aligned to a 2-cycle pipeline.

---
 rtl/palette_colorizer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/palette_colorizer.sv
// Two-stage pixel colorizer: resolves prioritised, optionally blinking icon layers over a
// world-map pixel, then looks the winner up in run-time-writable 12-bit RGB palettes.
module palette_colorizer #(
  parameter int unsigned WORLD_BITS = 2,
  parameter int unsigned ICON_BITS  = 2,
  parameter int unsigned NUM_ICONS  = 2,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic                                                       video_on,
  input  logic [WORLD_BITS-1:0]                                      world_pixel,
  input  logic [NUM_ICONS*ICON_BITS-1:0]                             icon,
  input  logic [NUM_ICONS-1:0]                                       blink_en,
  input  logic                                                       pal_we,
  input  logic                                                       pal_sel,
  input  logic [(WORLD_BITS > ICON_BITS ? WORLD_BITS : ICON_BITS)-1:0] pal_addr,
  input  logic [11:0]                                                pal_wdata,
  output logic [3:0]                                                 red,
  output logic [3:0]                                                 green,
  output logic [3:0]                                                 blue,
  output logic                                                       pix_valid
);

  localparam int unsigned ADDR_W  = (WORLD_BITS > ICON_BITS) ? WORLD_BITS : ICON_BITS;
  localparam int unsigned WORLD_N = 1 << WORLD_BITS;
  localparam int unsigned ICON_N  = 1 << ICON_BITS;
  localparam int unsigned CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  function automatic logic [11:0] world_default(input int unsigned idx);
    case (idx)
      0:       return 12'hFFF;
      2:       return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] icon_default(input int unsigned idx);
    case (idx)
      2:       return 12'h0F0;
      3:       return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  logic [11:0]          world_pal_q [WORLD_N];
  logic [11:0]          world_pal_d [WORLD_N];
  logic [11:0]          icon_pal_q  [ICON_N];
  logic [11:0]          icon_pal_d  [ICON_N];
  logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic                 s1_video_q, s1_video_d;
  logic                 s1_src_q, s1_src_d;
  logic [ADDR_W-1:0]    s1_idx_q, s1_idx_d;
  logic [11:0]          rgb_q, rgb_d;
  logic                 pix_valid_q, pix_valid_d;

  logic                 hit;
  logic [ICON_BITS-1:0] code;
  logic [NUM_ICONS-1:0] mask;
  logic [NUM_ICONS-1:0] mask_sh;

  // Free-running blink divider; phase flips once per BLINK_DIV cycles
  always_comb begin
    blink_cnt_d   = blink_cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Stage 1: lowest-numbered visible, non-transparent layer wins; otherwise the world pixel
  always_comb begin
    s1_video_d = video_on;
    s1_src_d   = 1'b0;
    s1_idx_d   = ADDR_W'(world_pixel);
    hit        = 1'b0;
    code       = '0;
    mask       = blink_phase_q ? blink_en : '0;
    mask_sh    = '0;
    for (int i = 0; i < NUM_ICONS; i++) begin
      code    = ICON_BITS'(icon >> (i * ICON_BITS));
      mask_sh = mask >> i;
      if (!hit && (code != '0) && !mask_sh[0]) begin
        hit      = 1'b1;
        s1_src_d = 1'b1;
        s1_idx_d = ADDR_W'(code);
      end
    end
  end

  // Stage 2: palette lookup reads the contents held before this edge's write
  always_comb begin
    rgb_d       = '0;
    pix_valid_d = s1_video_q;
    if (s1_video_q) begin
      if (s1_src_q) rgb_d = icon_pal_q[s1_idx_q[ICON_BITS-1:0]];
      else          rgb_d = world_pal_q[s1_idx_q[WORLD_BITS-1:0]];
    end
  end

  always_comb begin
    world_pal_d = world_pal_q;
    icon_pal_d  = icon_pal_q;
    if (pal_we) begin
      if (pal_sel) icon_pal_d[pal_addr[ICON_BITS-1:0]]   = pal_wdata;
      else         world_pal_d[pal_addr[WORLD_BITS-1:0]] = pal_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORLD_N; i++) world_pal_q[WORLD_BITS'(i)] <= world_default(i);
      for (int unsigned i = 0; i < ICON_N; i++)  icon_pal_q[ICON_BITS'(i)]   <= icon_default(i);
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s1_video_q    <= 1'b0;
      s1_src_q      <= 1'b0;
      s1_idx_q      <= '0;
      rgb_q         <= '0;
      pix_valid_q   <= 1'b0;
    end else begin
      world_pal_q   <= world_pal_d;
      icon_pal_q    <= icon_pal_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s1_video_q    <= s1_video_d;
      s1_src_q      <= s1_src_d;
      s1_idx_q      <= s1_idx_d;
      rgb_q         <= rgb_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign pix_valid = pix_valid_q;

endmodule
